// File: rtl/router_sync_param.sv
// Router synchroniser: latches the destination channel, steers the FSM write strobe
// to that FIFO, and watches every channel for valid data that stays unread too long.
module router_sync_param #(
    parameter int N_CH    = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [N_CH-1:0]   read_enb,
    input  logic [N_CH-1:0]   empty,
    input  logic [N_CH-1:0]   full,
    output logic [N_CH-1:0]   vld_out,
    output logic [N_CH-1:0]   soft_reset,
    output logic              fifo_full,
    output logic [N_CH-1:0]   write_enb,
    output logic              addr_err
);
    localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W:0] CH_LIMIT = (ADDR_W + 1)'(N_CH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              dest_vld_q, dest_vld_d;
    logic              addr_err_q, addr_err_d;
    logic [N_CH-1:0]   soft_reset_q, soft_reset_d;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];

    assign vld_out    = ~empty;
    assign soft_reset = soft_reset_q;
    assign addr_err   = addr_err_q;

    always_comb begin
        dest_d     = dest_q;
        dest_vld_d = dest_vld_q;
        addr_err_d = 1'b0;
        if (detect_add) begin
            if ({1'b0, data_in} < CH_LIMIT) begin
                dest_d     = data_in;
                dest_vld_d = 1'b1;
            end else begin
                dest_vld_d = 1'b0;
                addr_err_d = 1'b1;
            end
        end
    end

    // Compare against each channel index rather than indexing by dest_q, so a
    // non-power-of-two N_CH never addresses a missing bit.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (dest_vld_q && dest_q == ADDR_W'(i)) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    always_comb begin
        soft_reset_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (vld_out[i] && !read_enb[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    soft_reset_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dest_q       <= '0;
            dest_vld_q   <= 1'b0;
            addr_err_q   <= 1'b0;
            soft_reset_q <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            dest_q       <= dest_d;
            dest_vld_q   <= dest_vld_d;
            addr_err_q   <= addr_err_d;
            soft_reset_q <= soft_reset_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_router_sync_param.sv
// Directed bench for router_sync_param: a default instance (3 ch, timeout 30)
// and a 4-channel instance with timeout 5; expectations flow through a queue.
module tb_router_sync_param;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: N_CH=3, ADDR_W=2, TIMEOUT=30
    logic       a_reset, a_detect_add, a_write_enb_reg, a_fifo_full, a_addr_err;
    logic [1:0] a_data_in;
    logic [2:0] a_read_enb, a_empty, a_full, a_vld_out, a_soft_reset, a_write_enb;

    // Instance B: N_CH=4, ADDR_W=2, TIMEOUT=5
    logic       b_reset, b_detect_add, b_write_enb_reg, b_fifo_full, b_addr_err;
    logic [1:0] b_data_in;
    logic [3:0] b_read_enb, b_empty, b_full, b_vld_out, b_soft_reset, b_write_enb;

    router_sync_param dut_a (
        .clock(clock), .reset(a_reset), .detect_add(a_detect_add), .data_in(a_data_in),
        .write_enb_reg(a_write_enb_reg), .read_enb(a_read_enb), .empty(a_empty),
        .full(a_full), .vld_out(a_vld_out), .soft_reset(a_soft_reset),
        .fifo_full(a_fifo_full), .write_enb(a_write_enb), .addr_err(a_addr_err)
    );

    router_sync_param #(.N_CH(4), .ADDR_W(2), .TIMEOUT(5)) dut_b (
        .clock(clock), .reset(b_reset), .detect_add(b_detect_add), .data_in(b_data_in),
        .write_enb_reg(b_write_enb_reg), .read_enb(b_read_enb), .empty(b_empty),
        .full(b_full), .vld_out(b_vld_out), .soft_reset(b_soft_reset),
        .fifo_full(b_fifo_full), .write_enb(b_write_enb), .addr_err(b_addr_err)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam int A_WE = 0, A_FF = 1, A_ERR = 2, A_SR = 3, A_VLD = 4;
    localparam int B_SR = 5, B_WE = 6, B_ERR = 7;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            A_WE:    return 32'(a_write_enb);
            A_FF:    return 32'(a_fifo_full);
            A_ERR:   return 32'(a_addr_err);
            A_SR:    return 32'(a_soft_reset);
            A_VLD:   return 32'(a_vld_out);
            B_SR:    return 32'(b_soft_reset);
            B_WE:    return 32'(b_write_enb);
            B_ERR:   return 32'(b_addr_err);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // n stalled edges; soft_reset must be 0 after each except the last, which shows pulse
    task automatic run_stall(input string tag, input int sel, input int n, input logic [31:0] pulse);
        for (int k = 1; k <= n; k++) begin
            push(tag, sel, (k == n) ? pulse : 32'h0);
            tick();
            drain();
        end
    endtask

    initial begin
        a_reset = 1'b1; a_detect_add = 1'b0; a_data_in = '0; a_write_enb_reg = 1'b0;
        a_read_enb = '0; a_empty = '1; a_full = '0;
        b_reset = 1'b1; b_detect_add = 1'b0; b_data_in = '0; b_write_enb_reg = 1'b0;
        b_read_enb = '0; b_empty = '1; b_full = '0;
        tick();
        tick();

        // Reset state; vld_out follows empty while reset is held
        a_write_enb_reg = 1'b1; a_full = '1; a_empty = 3'b010;
        push("rst_we", A_WE, 32'h0);
        push("rst_ff", A_FF, 32'h0);
        push("rst_vld", A_VLD, 32'h5);
        push("rst_err", A_ERR, 32'h0);
        push("rst_sr", A_SR, 32'h0);
        #1 drain();
        a_write_enb_reg = 1'b0; a_full = '0; a_empty = '1;
        tick();
        a_reset = 1'b0;

        // Steering to channel 2 and its full flag
        a_detect_add = 1'b1; a_data_in = 2'd2;
        tick();
        a_detect_add = 1'b0; a_write_enb_reg = 1'b1;
        push("steer_we2", A_WE, 32'h4);
        push("steer_ff_clear", A_FF, 32'h0);
        #1 drain();
        a_full = 3'b100;
        push("steer_ff2", A_FF, 32'h1);
        #1 drain();
        a_full = 3'b001;
        push("steer_ff_other", A_FF, 32'h0);
        #1 drain();
        a_full = '0; a_write_enb_reg = 1'b0;

        // Capture latency: the write in the capture cycle still uses the old dest
        a_detect_add = 1'b1; a_data_in = 2'd0;
        tick();
        a_data_in = 2'd1; a_write_enb_reg = 1'b1;
        push("lat_old", A_WE, 32'h1);
        #1 drain();
        tick();
        a_detect_add = 1'b0;
        push("lat_new", A_WE, 32'h2);
        #1 drain();

        // Out-of-range address
        a_detect_add = 1'b1; a_data_in = 2'd3;
        push("bad_same_cycle", A_WE, 32'h2);
        push("bad_err_pre", A_ERR, 32'h0);
        #1 drain();
        push("bad_err_pulse", A_ERR, 32'h1);
        tick();
        drain();
        a_detect_add = 1'b0; a_full = '1;
        push("bad_we_off", A_WE, 32'h0);
        push("bad_ff_off", A_FF, 32'h0);
        #1 drain();
        push("bad_err_once", A_ERR, 32'h0);
        push("bad_we_hold", A_WE, 32'h0);
        tick();
        drain();
        a_full = '0; a_detect_add = 1'b1; a_data_in = 2'd1;
        tick();
        a_detect_add = 1'b0;
        push("recover_we", A_WE, 32'h2);
        push("recover_err", A_ERR, 32'h0);
        #1 drain();
        a_write_enb_reg = 1'b0;

        // Timeout on channel 1, then a repeat pulse while still stalled
        a_empty = 3'b101;
        push("vld_ch1", A_VLD, 32'h2);
        #1 drain();
        run_stall("to_first", A_SR, 30, 32'h2);
        run_stall("to_repeat", A_SR, 30, 32'h2);
        a_empty = '1;
        tick();

        // A single read restarts the count
        a_empty = 3'b101;
        run_stall("rd_pre", A_SR, 29, 32'h0);
        a_read_enb = 3'b010;
        push("rd_cycle", A_SR, 32'h0);
        tick();
        drain();
        a_read_enb = '0;
        run_stall("rd_post", A_SR, 30, 32'h2);
        a_empty = '1;
        tick();

        // Reset mid-count on channel 0
        a_empty = 3'b110;
        run_stall("rst_pre", A_SR, 29, 32'h0);
        a_reset = 1'b1;
        push("rst_mid", A_SR, 32'h0);
        tick();
        drain();
        a_reset = 1'b0;
        run_stall("rst_post", A_SR, 30, 32'h1);
        a_empty = '1;

        // Parametrised instance: address 3 is legal with four channels
        b_reset = 1'b0;
        b_detect_add = 1'b1; b_data_in = 2'd3;
        push("b_err", B_ERR, 32'h0);
        tick();
        drain();
        b_detect_add = 1'b0; b_write_enb_reg = 1'b1;
        push("b_we3", B_WE, 32'h8);
        #1 drain();
        b_write_enb_reg = 1'b0;
        b_empty = 4'b0111;
        run_stall("b_pre", B_SR, 4, 32'h0);
        b_reset = 1'b1;
        push("b_rst_mid", B_SR, 32'h0);
        tick();
        drain();
        b_reset = 1'b0;
        run_stall("b_post", B_SR, 5, 32'h8);
        run_stall("b_again", B_SR, 5, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/router_sync_param.md
Name: router_sync_param

Overview:
- Parametrised synchroniser between the router FSM, the register block and N output FIFOs.
- Latches the destination address on detect_add, then steers write_enb_reg to the selected FIFO and reflects that FIFO's full flag.
- Drives per-channel valid outputs from the FIFO empty flags.
- Raises a one-cycle soft reset on any channel whose valid data sits unread for TIMEOUT consecutive cycles.
- Adds address-range checking with an error pulse.

Parameters:
- N_CH, 3: number of output channels/FIFOs (2..2^ADDR_W).
- ADDR_W, 2: width of the destination address field.
- TIMEOUT, 30: consecutive unread-valid cycles before soft reset (>=2).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- detect_add  in  1  capture data_in as destination this edge.
- data_in  in  ADDR_W  destination address from header byte.
- write_enb_reg  in  1  write request from router FSM.
- read_enb  in  N_CH  per-channel read enable from downstream.
- empty  in  N_CH  per-FIFO empty flags.
- full  in  N_CH  per-FIFO full flags.
- vld_out  out  N_CH  per-channel data valid.
- soft_reset  out  N_CH  per-channel timeout reset pulse.
- fifo_full  out  1  full flag of the selected FIFO.
- write_enb  out  N_CH  one-hot write enable to the FIFOs.
- addr_err  out  1  one-cycle pulse: captured address out of range.

Behaviour:
- Reset (reset=1 at edge):
  - dest=0 and dest_vld=0.
  - All timeout counters=0, soft_reset=0, addr_err=0.
  - vld_out tracks empty combinationally, even during reset.
- Destination register: a true flop, no latches.
  - On detect_add with data_in<N_CH: dest<=data_in, dest_vld<=1.
  - On detect_add with data_in>=N_CH: dest_vld<=0 and addr_err<=1 for exactly one cycle.
  - Without detect_add: dest holds.
- Steering (combinational from the registered dest):
  - When dest_vld=1: write_enb[dest]=write_enb_reg, all other bits 0; fifo_full=full[dest].
  - When dest_vld=0: write_enb=0, fifo_full=0.
  - detect_add and write_enb_reg in the same cycle: the write uses the old dest; the new dest is effective the next cycle (one-cycle capture latency).
- Valid: vld_out[i] = ~empty[i], combinational, zero latency.
- Timeout counter per channel i, width clog2(TIMEOUT)+1:
  - vld_out[i]=1 and read_enb[i]=0: count increments.
  - read_enb[i]=1 or vld_out[i]=0: count clears to 0 the same edge.
  - When count==TIMEOUT-1 and the increment condition holds: soft_reset[i]<=1 for one cycle, count<=0. The pulse therefore appears on the edge after TIMEOUT consecutive stalled cycles.
  - soft_reset[i] is 0 in every other cycle. A channel still stalled after the pulse restarts counting from 0 and pulses again every TIMEOUT cycles.
- Channels are fully independent; simultaneous timeouts on several channels produce simultaneous pulses.
- soft_reset does not alter dest or dest_vld.
- Reset mid-count: counters clear and no pulse is issued that edge, even if the count would have hit TIMEOUT-1.
- Counters saturate logically through the clear at TIMEOUT-1 and never wrap.

Test Plan:
- Steering, defaults: reset; detect_add=1, data_in=2; next cycle write_enb_reg=1 -> write_enb=3'b100; full[2]=1 gives fifo_full=1; full[0]=1 alone gives fifo_full=0.
- Capture latency: dest=0; in one cycle detect_add=1, data_in=1, write_enb_reg=1 -> write_enb=3'b001 that cycle, 3'b010 the following cycle.
- Invalid address: detect_add, data_in=3 (N_CH=3) -> addr_err high exactly 1 cycle; write_enb=0 and fifo_full=0 while write_enb_reg=1 until a valid address is captured.
- Timeout fires: empty[1]=0, read_enb[1]=0 held -> soft_reset[1] pulses one cycle after the 30th stalled edge, other bits 0; still stalled -> next pulse 30 cycles later.
- Timeout cleared by read: stall 29 cycles, read_enb[1]=1 for 1 cycle, stall again -> no pulse until 30 further stalled cycles.
- Reset mid-count: stall channel 0 for 29 cycles, assert reset 1 cycle -> no pulse; pulse only after 30 new stalled cycles. Repeat with N_CH=4, ADDR_W=2, TIMEOUT=5 to check parametrisation.
